// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: h/v counters, sync/blank decode,
// and a ce-qualified output pipeline so all outputs leave the block mutually aligned.
module vga_timing_gen #(
    parameter int CW       = 11,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 8,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 56,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 2,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 41,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int LAT      = 1,
    parameter int FRAME_W  = 8
) (
    input  logic               pixel_clk,
    input  logic               rst_n,
    input  logic               ce,
    output logic               HS,
    output logic               VS,
    output logic               blank,
    output logic               de,
    output logic [CW-1:0]      hcounter,
    output logic [CW-1:0]      vcounter,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (LAT < 1 || LAT > 4) begin : g_bad_lat
        $error("vga_timing_gen: LAT must be in 1..4");
    end
    if (CW < 1 || CW > 30 || H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_cw
        $error("vga_timing_gen: H_TOTAL-1 / V_TOTAL-1 must fit in CW bits");
    end

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    // Boundaries can reach 2^CW when a porch is zero, so compare one bit wider.
    localparam logic [CW:0] H_ACT_END  = (CW+1)'(H_ACTIVE);
    localparam logic [CW:0] H_SYNC_BEG = (CW+1)'(H_ACTIVE + H_FP);
    localparam logic [CW:0] H_SYNC_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW:0] V_ACT_END  = (CW+1)'(V_ACTIVE);
    localparam logic [CW:0] V_SYNC_BEG = (CW+1)'(V_ACTIVE + V_FP);
    localparam logic [CW:0] V_SYNC_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);

    typedef struct packed {
        logic               vld;
        logic               hsync;
        logic               vsync;
        logic               act;
        logic [CW-1:0]      h;
        logic [CW-1:0]      v;
        logic [FRAME_W-1:0] fr;
    } pix_t;

    logic [CW-1:0]      h_q, h_d, v_q, v_d;
    logic [FRAME_W-1:0] f_q, f_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    pix_t               cur;
    pix_t               pipe_q [LAT];
    pix_t               pipe_d [LAT];

    always_comb begin
        cur       = '0;
        cur.vld   = 1'b1;
        cur.h     = h_q;
        cur.v     = v_q;
        cur.fr    = f_q;
        cur.act   = ({1'b0, h_q} < H_ACT_END) && ({1'b0, v_q} < V_ACT_END);
        cur.hsync = ({1'b0, h_q} >= H_SYNC_BEG) && ({1'b0, h_q} < H_SYNC_END);
        cur.vsync = ({1'b0, v_q} >= V_SYNC_BEG) && ({1'b0, v_q} < V_SYNC_END);

        h_d = h_q;
        v_d = v_q;
        f_d = f_q;
        if (ce) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                if (v_q == V_LAST) begin
                    v_d = '0;
                    f_d = f_q + 1'b1;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        // Pulses are one clock wide: they are only raised on the ce edge that
        // loads a valid h=0 pixel into the last stage.
        pipe_d        = pipe_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if (ce) begin
            pipe_d[0] = cur;
            for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
            line_start_d  = pipe_d[LAT-1].vld && (pipe_d[LAT-1].h == '0);
            frame_start_d = line_start_d && (pipe_d[LAT-1].v == '0);
        end
    end

    always_ff @(posedge pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q           <= '0;
            v_q           <= '0;
            f_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            f_q           <= f_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            for (int i = 0; i < LAT; i++) pipe_q[i] <= pipe_d[i];
        end
    end

    assign HS          = pipe_q[LAT-1].hsync ? H_POL : ~H_POL;
    assign VS          = pipe_q[LAT-1].vsync ? V_POL : ~V_POL;
    assign de          = pipe_q[LAT-1].act;
    assign blank       = ~pipe_q[LAT-1].act;
    assign hcounter    = pipe_q[LAT-1].h;
    assign vcounter    = pipe_q[LAT-1].v;
    assign frame_cnt   = pipe_q[LAT-1].fr;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, LAT=3 inverted polarity, tiny raster)
// checked every clock against a model that maps the ce-edge count to a raster position.
module tb_vga_timing_gen;
    logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0;
    always #5 clk = ~clk;

    int tests = 0, fails = 0, n = 0;
    bit last_ce = 1'b0;

    int HA [3] = '{640, 640, 4};
    int HF [3] = '{8, 8, 1};
    int HSN[3] = '{96, 96, 1};
    int HB [3] = '{56, 56, 1};
    int VA [3] = '{480, 480, 2};
    int VF [3] = '{2, 2, 1};
    int VSN[3] = '{2, 2, 1};
    int VB [3] = '{41, 41, 1};
    bit HP [3] = '{1'b0, 1'b1, 1'b0};
    bit VP [3] = '{1'b0, 1'b1, 1'b0};
    int LT [3] = '{1, 3, 1};
    int FW [3] = '{8, 8, 2};

    logic hs0, vs0, bl0, de0, ls0, fs0;
    logic hs1, vs1, bl1, de1, ls1, fs1;
    logic hs2, vs2, bl2, de2, ls2, fs2;
    logic [10:0] hc0, vc0, hc1, vc1, hc2, vc2;
    logic [7:0]  fc0, fc1;
    logic [1:0]  fc2;
    logic [45:0] obs [3];

    assign obs[0] = {hs0, vs0, bl0, de0, ls0, fs0, 5'b0, hc0, 5'b0, vc0, fc0};
    assign obs[1] = {hs1, vs1, bl1, de1, ls1, fs1, 5'b0, hc1, 5'b0, vc1, fc1};
    assign obs[2] = {hs2, vs2, bl2, de2, ls2, fs2, 5'b0, hc2, 5'b0, vc2, 6'b0, fc2};

    vga_timing_gen u0 (
        .pixel_clk(clk), .rst_n(rst_n), .ce(ce), .HS(hs0), .VS(vs0), .blank(bl0), .de(de0),
        .hcounter(hc0), .vcounter(vc0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0));

    vga_timing_gen #(.LAT(3), .H_POL(1'b1), .V_POL(1'b1)) u1 (
        .pixel_clk(clk), .rst_n(rst_n), .ce(ce), .HS(hs1), .VS(vs1), .blank(bl1), .de(de1),
        .hcounter(hc1), .vcounter(vc1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1));

    vga_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1),
                     .V_SYNC(1), .V_BP(1), .FRAME_W(2)) u2 (
        .pixel_clk(clk), .rst_n(rst_n), .ce(ce), .HS(hs2), .VS(vs2), .blank(bl2), .de(de2),
        .hcounter(hc2), .vcounter(vc2), .line_start(ls2), .frame_start(fs2), .frame_cnt(fc2));

    // n ce edges since reset release put pixel number n-LAT (raster order) on the outputs.
    function automatic logic [45:0] model(int k);
        int ht, vt, p, h, v, fr;
        bit act, hsa, vsa, ls, fs;
        logic [10:0] hh, vv;
        logic [7:0] ff;
        ht = HA[k] + HF[k] + HSN[k] + HB[k];
        vt = VA[k] + VF[k] + VSN[k] + VB[k];
        h = 0; v = 0; fr = 0;
        act = 0; hsa = 0; vsa = 0; ls = 0; fs = 0;
        if (rst_n && n >= LT[k]) begin
            p   = n - LT[k];
            h   = p % ht;
            v   = (p / ht) % vt;
            fr  = (p / (ht * vt)) % (1 << FW[k]);
            act = (h < HA[k]) && (v < VA[k]);
            hsa = (h >= HA[k] + HF[k]) && (h < HA[k] + HF[k] + HSN[k]);
            vsa = (v >= VA[k] + VF[k]) && (v < VA[k] + VF[k] + VSN[k]);
            ls  = last_ce && (h == 0);
            fs  = ls && (v == 0);
        end
        hh = 11'(h);
        vv = 11'(v);
        ff = 8'(fr);
        return {(hsa ? HP[k] : ~HP[k]), (vsa ? VP[k] : ~VP[k]), ~act, act, ls, fs,
                5'b0, hh, 5'b0, vv, ff};
    endfunction

    task automatic check(string tag);
        for (int k = 0; k < 3; k++) begin
            logic [45:0] e;
            e = model(k);
            tests++;
            assert (obs[k] === e) else begin
                fails++;
                $error("FAIL %s dut%0d n=%0d got %h want %h", tag, k, n, obs[k], e);
            end
        end
    endtask

    task automatic step(bit ce_v, string tag);
        ce = ce_v;
        @(posedge clk);
        if (rst_n && ce) n++;
        last_ce = rst_n && ce;
        #1 check(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (5) step(1'b1, "reset");
        rst_n = 1'b1;
        step(1'b1, "startup");
        tests++;
        assert ({hc0, vc0, de0, ls0, fs0} === {11'd0, 11'd0, 3'b111}) else begin
            fails++;
            $error("FAIL first_pixel got %h want %h", {hc0, vc0, de0, ls0, fs0}, {25'd7});
        end
        repeat (1999) step(1'b1, "run");
        for (int i = 0; i < 1700; i++) step(i % 2 == 0, "ce_half");
        repeat (50) step(1'b0, "ce_off");
        repeat (3000) step($urandom_range(0, 3) != 0, "ce_rand");
        #2 rst_n = 1'b0;
        n = 0;
        last_ce = 1'b0;
        #1 check("rst_async");
        repeat (3) step(1'b1, "rst_hold");
        rst_n = 1'b1;
        repeat (1000) step($urandom_range(0, 1) != 0, "after_rst");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator for the display path: produces horizontal/vertical sync, blanking, data-enable, pixel coordinates and line/frame markers from a single pixel clock. It is the next-generation replacement for the fixed 640x480 timing block. It adds the following over that block:
- Porch, sync and active lengths set per instance.
- Selectable sync polarity.
- A pixel clock-enable, so a faster system clock can be divided down.
- A configurable output pipeline, so downstream pixel logic can be latency-matched.
- Exact wrap at the line/frame total.

## Interface
- CW, 11, width of coordinate counters; H_TOTAL-1 and V_TOTAL-1 must fit in CW bits
- H_ACTIVE, 640, visible pixels per line
- H_FP, 8, horizontal front porch length (pixels)
- H_SYNC, 96, horizontal sync pulse length (pixels)
- H_BP, 56, horizontal back porch length (pixels); H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800
- V_ACTIVE, 480, visible lines per frame
- V_FP, 2, vertical front porch length (lines)
- V_SYNC, 2, vertical sync length (lines)
- V_BP, 41, vertical back porch length (lines); V_TOTAL = 525
- H_POL, 0, HS active level (0 = active-low)
- V_POL, 0, VS active level (0 = active-low)
- LAT, 1, output pipeline depth in ce-qualified stages, legal range 1..4
- FRAME_W, 8, frame counter width

Ports:
- pixel_clk  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- ce  input  1  pixel enable; raster advances only on edges where ce=1
- HS  output  1  horizontal sync
- VS  output  1  vertical sync
- blank  output  1  1 outside the active area
- de  output  1  data enable, always ~blank
- hcounter  output  CW  horizontal position of the pixel currently on the outputs
- vcounter  output  CW  vertical position of the pixel currently on the outputs
- line_start  output  1  one-pixel_clk pulse when the outputs move to hcounter=0
- frame_start  output  1  one-pixel_clk pulse when the outputs move to (0,0)
- frame_cnt  output  FRAME_W  index of the frame currently on the outputs

## Operation
- Internal counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), reset to 0.
- Counter advance, on a ce edge only:
  - h wraps H_TOTAL-1 -> 0.
  - v increments only when h wraps, and itself wraps V_TOTAL-1 -> 0.
- Decode of the current (h,v):
  - active when h<H_ACTIVE and v<V_ACTIVE.
  - hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC. vsync depends on v only, not on h.
- Output pipeline:
  - The decode plus (h,v) enter a pipeline of LAT stages. Every stage loads only on ce edges.
  - All outputs come from the final stage, so HS, VS, blank, de, hcounter, vcounter and frame_cnt are mutually aligned for every LAT.
- HS = H_POL when hsync is asserted, else ~H_POL. VS follows the same rule with V_POL.
- frame_cnt:
  - The internal frame index increments when v wraps to 0 and wraps modulo 2^FRAME_W.
  - It travels through the pipeline with (h,v), so it changes on the same output cycle that (0,0) appears.
- line_start / frame_start:
  - High for exactly one pixel_clk cycle: the cycle after the ce edge that loads hcounter=0 (resp. (0,0)) into the final stage.
  - Low while ce is held low, even though the outputs still show h=0.
- ce=0 for any duration: all outputs and counters are frozen, with no pulse regeneration.

## Timing
- Reset (async assert, sync release inside the pipeline), all outputs:
  - HS=~H_POL, VS=~V_POL, blank=1, de=0.
  - hcounter=0, vcounter=0, frame_cnt=0.
  - line_start=0, frame_start=0.
- Internal h=v=0 during reset.
- Latency: the pixel at internal (h,v) reaches the outputs on the LAT-th ce edge after it is current.
  - After reset release, (0,0) appears after the LAT-th ce edge. At that point blank=0, de=1, and line_start and frame_start both pulse.
  - Until then, all pipeline stages hold reset values.
- Per line with ce tied high:
  - de high for H_ACTIVE consecutive clocks, blank high for the remaining H_TOTAL-H_ACTIVE clocks.
  - HS active for exactly H_SYNC clocks.
- Frame period = H_TOTAL*V_TOTAL ce edges. VS is active for exactly V_SYNC*H_TOTAL ce edges.
- Reset asserted mid-frame forces the reset values immediately. No partial pulse follows release.
- Illegal parameters (LAT outside 1..4, or totals not fitting CW) stop elaboration via a generate-time error.

## Test plan
- Reset/startup:
  - Stimulus: defaults, LAT=1, ce=1; hold rst_n low 5 clocks, then release.
  - Required: reset values during reset; after the 1st ce edge, hcounter=0, vcounter=0, de=1, frame_start=line_start=1 for one clock.
- Horizontal timing:
  - Stimulus: defaults, ce=1.
  - Required: HS low exactly while hcounter is 648..743; de high exactly while hcounter is 0..639; hcounter goes 799->0 and vcounter increments at that step.
- Vertical timing and wrap:
  - Stimulus: defaults, run more than one frame.
  - Required: VS low for lines 482..483 (1600 clocks); vcounter goes 524->0; frame_cnt 0->1; frame period 420000 clocks.
- Clock-enable:
  - Stimulus: ce=1 every 2nd clock.
  - Required: each hcounter value held 2 clocks; line_start high 1 clock per line; a ce=0 burst of 50 clocks freezes all outputs.
- Latency/polarity:
  - Stimulus: LAT=3, H_POL=1, V_POL=1.
  - Required: (0,0) appears after the 3rd ce edge; HS high for hcounter 648..743; HS, blank and hcounter stay mutually aligned as at LAT=1.
- Small raster:
  - Stimulus: H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, FRAME_W=2.
  - Required: 35-clock frames; frame_cnt sequence 0,1,2,3,0; reset asserted mid-line returns reset values immediately.
